or1200_checker_alarm_ctrl: RTL and testbench
============================================

// Module: or1200_checker_alarm_ctrl
// PURPOSE
//  Response sequencer for the CPU privilege checker. Filters checker verdicts (sr_ok, pipeline_ok,
//  mmus_ok), escalates persistent or repeated faults to an alarm, requests a CPU exception and
//  stalls the pipeline, then either recovers under supervisor-authorised clear or locks the core
//  until reset. Sits between the checker and the or1200_cpu except/freeze logic.
// PARAMETERS
//  GRACE_CYCLES  8'd16  post-reset cycles during which checker verdicts are ignored
//  FILTER_LEN    4'd3   consecutive faulty cycles that escalate SUSPECT -> ALARM
//  GLITCH_MAX    4'd4   transient faults (SUSPECT exits) tolerated before escalating to ALARM
//  ACK_TIMEOUT   8'd32  cycles ALARM waits for except_ack before LOCKED
// PORTS
//  clk          in   1  core clock
//  rst          in   1  reset; asynchronous, active-high
//  sr_ok        in   1  checker: SR consistency verdict (1 = good)
//  pipeline_ok  in   1  checker: pipeline/flush verdict (1 = good)
//  mmus_ok      in   1  checker: MMU enable verdict (1 = good)
//  secure_supv  in   3  checker: even parity = supervisor, odd parity = user
//  clear_req    in   1  software request to clear alarm (decoded SPR write strobe)
//  except_ack   in   1  CPU exception started (except_started)
//  except_req   out  1  one-cycle pulse requesting security exception
//  cpu_stall    out  1  freeze request to CPU
//  alarm        out  1  alarm indication, sticky until authorised clear
//  locked       out  1  core locked; only rst releases
//  fault_vec    out  3  sticky {mmus, pipeline, sr} fault causes
//  glitch_cnt   out  4  transient-fault count since last clear
//  state        out  3  FSM state for debug
// BEHAVIOUR
//  - Reset (async, rst=1): state=BOOT, all outputs 0, all counters 0.
//  - fault_now = ~sr_ok | ~pipeline_ok | ~mmus_ok; supv = ~^secure_supv. All inputs sampled posedge clk.
//  - fault_vec bits OR in {~mmus_ok,~pipeline_ok,~sr_ok} every cycle outside BOOT; cleared only on clear.
//  - States: BOOT=0, ARMED=1, SUSPECT=2, ALARM=3, RECOVER=4, LOCKED=5.
//  - BOOT: grace_cnt counts up; inputs ignored; at grace_cnt==GRACE_CYCLES-1 -> ARMED.
//  - ARMED: fault_now -> SUSPECT, filter_cnt=1.
//  - SUSPECT: fault_now: filter_cnt+1; when new value == FILTER_LEN -> ALARM.
//    ~fault_now: glitch_cnt+1 (saturating at 4'hF); if new value >= GLITCH_MAX -> ALARM else ARMED.
//  - Entering ALARM: except_req=1 for exactly the first ALARM cycle; timeout_cnt=0.
//  - ALARM: cpu_stall=1, alarm=1; except_ack -> RECOVER; else timeout_cnt+1; at ACK_TIMEOUT-1 -> LOCKED.
//    except_ack in the same cycle as the timeout terminal count wins (-> RECOVER).
//  - RECOVER: cpu_stall=0, alarm=1. fault_now -> LOCKED (priority over clear).
//    clear_req & supv -> ARMED; clears alarm, fault_vec, glitch_cnt, filter_cnt.
//    clear_req & ~supv: ignored, and sets fault_vec[1] (illegal clear attempt).
//  - LOCKED: cpu_stall=1, alarm=1, locked=1; no exit except rst; clear_req ignored.
//  - clear_req in ARMED/SUSPECT with supv: clears glitch_cnt and fault_vec; state unchanged.
//  - alarm asserted in ALARM/RECOVER/LOCKED; cpu_stall in ALARM/LOCKED; all registered outputs.
//  - Unreachable state encodings -> LOCKED (fail-secure).
//  - rst mid-operation (any state, incl. LOCKED) returns to BOOT on same edge, outputs 0 at once.
// TESTING
//  1 rst, hold sr_ok=0 during 16 grace cycles -> state stays BOOT, fault_vec=0, then ARMED at cycle 16.
//  2 ARMED, mmus_ok=0 for 3 cycles -> ALARM on 3rd edge, except_req 1-cycle pulse, fault_vec=3'b100.
//  3 Four 1-cycle pipeline_ok=0 glitches -> glitch_cnt 1..4, ALARM on 4th exit from SUSPECT.
//  4 ALARM, except_ack at cycle 5 -> RECOVER, cpu_stall=0; clear_req with secure_supv=3'b001 (user)
//    -> stays RECOVER, fault_vec[1]=1; clear_req with 3'b011 -> ARMED, alarm=0, glitch_cnt=0.
//  5 ALARM, no except_ack for 32 cycles -> LOCKED, locked=1; clear_req+supv -> no change; rst -> BOOT.
//  6 RECOVER, sr_ok=0 with clear_req&supv same cycle -> LOCKED (fault priority).

Source files
------------

// File: rtl/or1200_checker_alarm_ctrl_if.sv
// Checker-to-sequencer bus: checker verdicts and software strobes in, alarm/response signals out.
interface or1200_checker_alarm_ctrl_if;
   logic       sr_ok;
   logic       pipeline_ok;
   logic       mmus_ok;
   logic [2:0] secure_supv;
   logic       clear_req;
   logic       except_ack;
   logic       except_req;
   logic       cpu_stall;
   logic       alarm;
   logic       locked;
   logic [2:0] fault_vec;
   logic [3:0] glitch_cnt;
   logic [2:0] state;

   modport master (
      output sr_ok, pipeline_ok, mmus_ok, secure_supv, clear_req, except_ack,
      input  except_req, cpu_stall, alarm, locked, fault_vec, glitch_cnt, state
   );

   modport slave (
      input  sr_ok, pipeline_ok, mmus_ok, secure_supv, clear_req, except_ack,
      output except_req, cpu_stall, alarm, locked, fault_vec, glitch_cnt, state
   );
endinterface

// File: rtl/or1200_checker_alarm_ctrl.sv
// Response sequencer for the CPU privilege checker: filters verdicts, escalates to an alarm,
// requests an exception and stalls, then recovers on a supervisor clear or locks until reset.
module or1200_checker_alarm_ctrl #(
   parameter logic [7:0] GRACE_CYCLES = 8'd16,
   parameter logic [3:0] FILTER_LEN   = 4'd3,
   parameter logic [3:0] GLITCH_MAX   = 4'd4,
   parameter logic [7:0] ACK_TIMEOUT  = 8'd32
) (
   input  logic                            clk,
   input  logic                            rst,
   or1200_checker_alarm_ctrl_if.slave      bus
);

   localparam int unsigned CNT8_W = 8;
   localparam int unsigned CNT4_W = 4;

   typedef enum logic [2:0] {
      ST_BOOT    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_SUSPECT = 3'd2,
      ST_ALARM   = 3'd3,
      ST_RECOVER = 3'd4,
      ST_LOCKED  = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [CNT8_W-1:0]   grace_q, grace_d;
   logic [CNT8_W-1:0]   timeout_q, timeout_d;
   logic [CNT4_W-1:0]   filter_q, filter_d;
   logic [CNT4_W-1:0]   glitch_q, glitch_d;
   logic [2:0]          fault_vec_q, fault_vec_d;
   logic                except_req_q, except_req_d;
   logic                cpu_stall_q, cpu_stall_d;
   logic                alarm_q, alarm_d;
   logic                locked_q, locked_d;

   logic                fault_now;
   logic                supv;
   logic [2:0]          fault_bits;
   logic [CNT4_W-1:0]   filter_inc;
   logic [CNT4_W-1:0]   glitch_inc;

   // Verdict decode: any bad verdict is a fault; even parity on secure_supv means supervisor.
   always_comb begin
      fault_bits = {~bus.mmus_ok, ~bus.pipeline_ok, ~bus.sr_ok};
      fault_now  = |fault_bits;
      supv       = ~^bus.secure_supv;
      filter_inc = CNT4_W'(filter_q + 4'd1);
      glitch_inc = (glitch_q == 4'hF) ? 4'hF : CNT4_W'(glitch_q + 4'd1);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      grace_d     = grace_q;
      timeout_d   = timeout_q;
      filter_d    = filter_q;
      glitch_d    = glitch_q;
      fault_vec_d = (state_q == ST_BOOT) ? fault_vec_q : (fault_vec_q | fault_bits);

      case (state_q)
         ST_BOOT: begin
            if (grace_q == CNT8_W'(GRACE_CYCLES - 8'd1)) state_d = ST_ARMED;
            else                                         grace_d = CNT8_W'(grace_q + 8'd1);
         end
         ST_ARMED: begin
            if (bus.clear_req && supv) begin
               glitch_d    = '0;
               fault_vec_d = fault_bits;
            end
            if (fault_now) begin
               state_d  = ST_SUSPECT;
               filter_d = 4'd1;
            end
         end
         ST_SUSPECT: begin
            if (bus.clear_req && supv) begin
               glitch_d    = '0;
               fault_vec_d = fault_bits;
            end
            if (fault_now) begin
               filter_d = filter_inc;
               if (filter_inc == FILTER_LEN) begin
                  state_d   = ST_ALARM;
                  timeout_d = '0;
               end
            end else begin
               // A transient fault counts toward the glitch budget even alongside a clear.
               glitch_d = glitch_inc;
               filter_d = '0;
               if (glitch_inc >= GLITCH_MAX) begin
                  state_d   = ST_ALARM;
                  timeout_d = '0;
               end else begin
                  state_d = ST_ARMED;
               end
            end
         end
         ST_ALARM: begin
            // A late acknowledge still wins over the timeout terminal count.
            if (bus.except_ack)                                 state_d   = ST_RECOVER;
            else if (timeout_q == CNT8_W'(ACK_TIMEOUT - 8'd1))  state_d   = ST_LOCKED;
            else                                                timeout_d = CNT8_W'(timeout_q + 8'd1);
         end
         ST_RECOVER: begin
            if (fault_now) begin
               state_d = ST_LOCKED;
            end else if (bus.clear_req) begin
               if (supv) begin
                  state_d     = ST_ARMED;
                  fault_vec_d = '0;
                  glitch_d    = '0;
                  filter_d    = '0;
               end else begin
                  fault_vec_d[1] = 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            state_d = ST_LOCKED;
         end
         default: begin
            state_d = ST_LOCKED;
         end
      endcase

      except_req_d = (state_d == ST_ALARM) && (state_q != ST_ALARM);
      alarm_d      = (state_d == ST_ALARM) || (state_d == ST_RECOVER) || (state_d == ST_LOCKED);
      cpu_stall_d  = (state_d == ST_ALARM) || (state_d == ST_LOCKED);
      locked_d     = (state_d == ST_LOCKED);
   end

   // State, counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_BOOT;
         grace_q      <= '0;
         timeout_q    <= '0;
         filter_q     <= '0;
         glitch_q     <= '0;
         fault_vec_q  <= '0;
         except_req_q <= 1'b0;
         cpu_stall_q  <= 1'b0;
         alarm_q      <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         grace_q      <= grace_d;
         timeout_q    <= timeout_d;
         filter_q     <= filter_d;
         glitch_q     <= glitch_d;
         fault_vec_q  <= fault_vec_d;
         except_req_q <= except_req_d;
         cpu_stall_q  <= cpu_stall_d;
         alarm_q      <= alarm_d;
         locked_q     <= locked_d;
      end
   end

   assign bus.except_req = except_req_q;
   assign bus.cpu_stall  = cpu_stall_q;
   assign bus.alarm      = alarm_q;
   assign bus.locked     = locked_q;
   assign bus.fault_vec  = fault_vec_q;
   assign bus.glitch_cnt = glitch_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_or1200_checker_alarm_ctrl.sv
// Directed bench for the checker alarm sequencer.
module tb_or1200_checker_alarm_ctrl;

   localparam logic [2:0] S_BOOT    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_SUSPECT = 3'd2;
   localparam logic [2:0] S_ALARM   = 3'd3;
   localparam logic [2:0] S_RECOVER = 3'd4;
   localparam logic [2:0] S_LOCKED  = 3'd5;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   or1200_checker_alarm_ctrl_if bus ();

   or1200_checker_alarm_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise an alarm by holding sr_ok low for three cycles from ARMED.
   task automatic raise_alarm(input string tag);
      bus.sr_ok = 1'b0;
      repeat (3) tick();
      bus.sr_ok = 1'b1;
      checks++;
      if ({bus.state, bus.except_req, bus.cpu_stall} !== {S_ALARM, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL %s_enter_alarm: got state=%0d req=%0b stall=%0b want state=3 req=1 stall=1",
                  tag, bus.state, bus.except_req, bus.cpu_stall);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.sr_ok = 1'b0; bus.pipeline_ok = 1'b1; bus.mmus_ok = 1'b1;
      bus.secure_supv = 3'b000; bus.clear_req = 1'b0; bus.except_ack = 1'b0;
      repeat (2) tick();
      checks++;
      if ({bus.state, bus.except_req, bus.cpu_stall, bus.alarm, bus.locked, bus.fault_vec, bus.glitch_cnt} !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs: got state=%0d fv=%b gc=%0d alarm=%0b want all zero",
                  bus.state, bus.fault_vec, bus.glitch_cnt, bus.alarm);
      end
      rst = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         tick();
         checks++;
         if ({bus.state, bus.fault_vec} !== {S_BOOT, 3'b000}) begin
            errors++;
            $display("FAIL grace_cycle_%0d: got state=%0d fv=%b want state=0 fv=000", i, bus.state, bus.fault_vec);
         end
      end
      tick();
      checks++;
      if (bus.state !== S_ARMED) begin
         errors++;
         $display("FAIL grace_exit: got state=%0d want 1", bus.state);
      end
      bus.sr_ok = 1'b1;
      tick();
      checks++;
      if ({bus.state, bus.fault_vec} !== {S_ARMED, 3'b000}) begin
         errors++;
         $display("FAIL armed_idle: got state=%0d fv=%b want state=1 fv=000", bus.state, bus.fault_vec);
      end
   endtask

   task automatic test_filter();
      bus.mmus_ok = 1'b0;
      tick();
      checks++;
      if (bus.state !== S_SUSPECT) begin
         errors++;
         $display("FAIL filter_1: got state=%0d want 2", bus.state);
      end
      tick();
      checks++;
      if ({bus.state, bus.except_req} !== {S_SUSPECT, 1'b0}) begin
         errors++;
         $display("FAIL filter_2: got state=%0d req=%0b want state=2 req=0", bus.state, bus.except_req);
      end
      tick();
      checks++;
      if ({bus.state, bus.except_req, bus.cpu_stall, bus.alarm, bus.fault_vec} !== {S_ALARM, 1'b1, 1'b1, 1'b1, 3'b100}) begin
         errors++;
         $display("FAIL filter_alarm: got state=%0d req=%0b stall=%0b alarm=%0b fv=%b want 3/1/1/1/100",
                  bus.state, bus.except_req, bus.cpu_stall, bus.alarm, bus.fault_vec);
      end
      bus.mmus_ok = 1'b1;
      tick();
      checks++;
      if ({bus.state, bus.except_req} !== {S_ALARM, 1'b0}) begin
         errors++;
         $display("FAIL except_pulse: got state=%0d req=%0b want state=3 req=0", bus.state, bus.except_req);
      end
      bus.except_ack = 1'b1;
      tick();
      bus.except_ack = 1'b0;
      checks++;
      if ({bus.state, bus.cpu_stall, bus.alarm} !== {S_RECOVER, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL filter_recover: got state=%0d stall=%0b alarm=%0b want 4/0/1", bus.state, bus.cpu_stall, bus.alarm);
      end
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      checks++;
      if ({bus.state, bus.alarm, bus.fault_vec} !== {S_ARMED, 1'b0, 3'b000}) begin
         errors++;
         $display("FAIL filter_clear: got state=%0d alarm=%0b fv=%b want 1/0/000", bus.state, bus.alarm, bus.fault_vec);
      end
   endtask

   task automatic test_glitch();
      for (int i = 1; i <= 4; i++) begin
         bus.pipeline_ok = 1'b0;
         tick();
         checks++;
         if (bus.state !== S_SUSPECT) begin
            errors++;
            $display("FAIL glitch_%0d_enter: got state=%0d want 2", i, bus.state);
         end
         bus.pipeline_ok = 1'b1;
         tick();
         checks++;
         if ({bus.state, bus.glitch_cnt} !== {(i < 4) ? S_ARMED : S_ALARM, 4'(i)}) begin
            errors++;
            $display("FAIL glitch_%0d_exit: got state=%0d gc=%0d want state=%0d gc=%0d",
                     i, bus.state, bus.glitch_cnt, (i < 4) ? S_ARMED : S_ALARM, i);
         end
      end
      checks++;
      if ({bus.fault_vec, bus.except_req} !== {3'b010, 1'b1}) begin
         errors++;
         $display("FAIL glitch_alarm: got fv=%b req=%0b want fv=010 req=1", bus.fault_vec, bus.except_req);
      end
      bus.except_ack = 1'b1;
      tick();
      bus.except_ack = 1'b0;
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      checks++;
      if ({bus.state, bus.glitch_cnt, bus.fault_vec} !== {S_ARMED, 4'd0, 3'b000}) begin
         errors++;
         $display("FAIL glitch_clear: got state=%0d gc=%0d fv=%b want 1/0/000", bus.state, bus.glitch_cnt, bus.fault_vec);
      end
   endtask

   task automatic test_recover();
      raise_alarm("recover");
      repeat (4) tick();
      checks++;
      if ({bus.state, bus.cpu_stall} !== {S_ALARM, 1'b1}) begin
         errors++;
         $display("FAIL recover_wait: got state=%0d stall=%0b want 3/1", bus.state, bus.cpu_stall);
      end
      bus.except_ack = 1'b1;
      tick();
      bus.except_ack = 1'b0;
      checks++;
      if ({bus.state, bus.cpu_stall} !== {S_RECOVER, 1'b0}) begin
         errors++;
         $display("FAIL recover_ack: got state=%0d stall=%0b want 4/0", bus.state, bus.cpu_stall);
      end
      bus.clear_req = 1'b1;
      bus.secure_supv = 3'b001;
      tick();
      checks++;
      if ({bus.state, bus.alarm, bus.fault_vec} !== {S_RECOVER, 1'b1, 3'b011}) begin
         errors++;
         $display("FAIL user_clear: got state=%0d alarm=%0b fv=%b want 4/1/011", bus.state, bus.alarm, bus.fault_vec);
      end
      bus.secure_supv = 3'b011;
      tick();
      bus.clear_req = 1'b0;
      bus.secure_supv = 3'b000;
      checks++;
      if ({bus.state, bus.alarm, bus.glitch_cnt, bus.fault_vec} !== {S_ARMED, 1'b0, 4'd0, 3'b000}) begin
         errors++;
         $display("FAIL supv_clear: got state=%0d alarm=%0b gc=%0d fv=%b want 1/0/0/000",
                  bus.state, bus.alarm, bus.glitch_cnt, bus.fault_vec);
      end
   endtask

   task automatic test_timeout();
      raise_alarm("timeout");
      repeat (31) tick();
      checks++;
      if (bus.state !== S_ALARM) begin
         errors++;
         $display("FAIL timeout_last_wait: got state=%0d want 3", bus.state);
      end
      tick();
      checks++;
      if ({bus.state, bus.locked, bus.cpu_stall, bus.alarm} !== {S_LOCKED, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL timeout_lock: got state=%0d locked=%0b stall=%0b alarm=%0b want 5/1/1/1",
                  bus.state, bus.locked, bus.cpu_stall, bus.alarm);
      end
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      checks++;
      if ({bus.state, bus.locked, bus.fault_vec} !== {S_LOCKED, 1'b1, 3'b001}) begin
         errors++;
         $display("FAIL locked_clear: got state=%0d locked=%0b fv=%b want 5/1/001", bus.state, bus.locked, bus.fault_vec);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.state, bus.locked, bus.alarm, bus.cpu_stall, bus.fault_vec} !== {S_BOOT, 1'b0, 1'b0, 1'b0, 3'b000}) begin
         errors++;
         $display("FAIL async_reset: got state=%0d locked=%0b alarm=%0b fv=%b want all zero",
                  bus.state, bus.locked, bus.alarm, bus.fault_vec);
      end
      tick();
      rst = 1'b0;
      repeat (16) tick();
      checks++;
      if (bus.state !== S_ARMED) begin
         errors++;
         $display("FAIL reboot_armed: got state=%0d want 1", bus.state);
      end
   endtask

   task automatic test_ack_at_terminal();
      raise_alarm("terminal");
      repeat (31) tick();
      bus.except_ack = 1'b1;
      tick();
      bus.except_ack = 1'b0;
      checks++;
      if ({bus.state, bus.locked} !== {S_RECOVER, 1'b0}) begin
         errors++;
         $display("FAIL ack_at_terminal: got state=%0d locked=%0b want 4/0", bus.state, bus.locked);
      end
   endtask

   task automatic test_fault_priority();
      bus.sr_ok = 1'b0;
      bus.clear_req = 1'b1;
      bus.secure_supv = 3'b000;
      tick();
      bus.sr_ok = 1'b1;
      bus.clear_req = 1'b0;
      checks++;
      if ({bus.state, bus.locked, bus.alarm} !== {S_LOCKED, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL fault_priority: got state=%0d locked=%0b alarm=%0b want 5/1/1", bus.state, bus.locked, bus.alarm);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.state, bus.locked} !== {S_BOOT, 1'b0}) begin
         errors++;
         $display("FAIL final_reset: got state=%0d locked=%0b want 0/0", bus.state, bus.locked);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_filter();
      test_glitch();
      test_recover();
      test_timeout();
      test_ack_at_terminal();
      test_fault_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
